lane_gather_reg: RTL and testbench
==================================

// Module: lane_gather_reg
// PURPOSE
//  Width converter: packs NUM_LANES narrow words, arriving one per cycle over valid/ready,
//  into one wide register and presents it both as a flat bus and as per-lane slices.
//  Parametrised successor of our fixed 8-bit split-port register; adds handshakes,
//  partial-word flush and backpressure. Sits between narrow serial sources and wide datapaths.
// PARAMETERS
//  LANE_W     8  bits per input word / output lane (>=1)
//  NUM_LANES  4  words packed per output word (>=2)
//  LSB_FIRST  1  1: first accepted word lands in lane 0; 0: first word lands in lane NUM_LANES-1
// PORTS
//  clk        in   1                  clock; all state updates on rising edge
//  rst        in   1                  synchronous, active-high reset
//  in_valid   in   1                  input word valid
//  in_ready   out  1                  input word accepted when in_valid && in_ready
//  in_data    in   LANE_W             input word
//  flush      in   1                  close the current partial word (one-cycle pulse)
//  out_valid  out  1                  packed word valid
//  out_ready  in   1                  consumer accepts when out_valid && out_ready
//  out_data   out  NUM_LANES*LANE_W   packed word (flat)
//  out_lanes  out  [NUM_LANES][LANE_W] same storage as out_data, unpacked per lane
//  out_count  out  $clog2(NUM_LANES+1) number of valid lanes in out_data (NUM_LANES if full)
// BEHAVIOUR
//  - Reset: state=FILL, lane counter=0, storage=0, out_valid=0, out_count=0; in_ready=1 after reset.
//  - FSM: FILL (collecting) -> HOLD (out_valid=1, waiting for out_ready).
//  - FILL: each accepted word is written to the lane selected by the counter; counter++.
//    When the NUM_LANES-th word is accepted: -> HOLD next cycle, out_count=NUM_LANES.
//  - flush in FILL with counter>0 (counting a word accepted in the same cycle): -> HOLD,
//    out_count=filled lanes, unfilled lanes read 0. flush with counter=0 and no word: ignored.
//  - HOLD: out_data/out_lanes/out_count stable until handshake. in_ready = out_ready, so the
//    first word of the next packet is accepted in the drain cycle (zero-bubble streaming);
//    it goes into lane 0 (or NUM_LANES-1) with counter=1. No drain -> in_ready=0.
//  - Drain with no simultaneous input: -> FILL, counter=0, storage cleared to 0.
//  - flush while in HOLD: ignored (word is already closed).
//  - Latency: last input word to out_valid = 1 cycle. Throughput: one word per cycle, sustained.
//  - Counter wraps at NUM_LANES to 0; never indexes past the last lane.
//  - rst mid-packet: partial data discarded, outputs return to reset values next cycle.
//  - in_data is ignored when in_valid=0; X on in_data must not reach storage.
// CONFIGURATION
//  LANE_GATHER_PARITY_EN defined: adds output out_parity [NUM_LANES], even parity per lane,
//   registered alongside the storage, valid with out_valid; unfilled lanes report 0.
//  Not defined: port and parity logic absent; all other behaviour identical.
// STRUCTURE
//  lane_gather_pkg: typedef enum logic {FILL, HOLD} lg_state_e; function lg_cnt_w(n)
//   = $clog2(n+1); localparam-style helper for lane index from counter and LSB_FIRST.
//  Single module; no sub-module needed. out_data and out_lanes alias one storage array.
// TESTING
//  1 Reset, NUM_LANES=4: send 11,22,33,44 back-to-back -> out_data=0x44332211, out_count=4,
//    out_valid 1 cycle after word 44.
//  2 LSB_FIRST=0, same stimulus -> out_data=0x11223344.
//  3 Send A1,B2 then flush -> out_data=0x0000B2A1, out_count=2; flush at count 0 -> no output.
//  4 out_ready low 5 cycles in HOLD -> in_ready=0, out_data stable; raise out_ready with
//    in_valid=1, data 55 -> word drained and 55 lands in lane 0 same cycle.
//  5 Continuous stream 16 words, out_ready=1 -> 4 packets, no idle cycles on in_ready.
//  6 rst asserted after 3 words -> out_valid=0, next 4 words form a clean packet;
//    with LANE_GATHER_PARITY_EN, data 0x07 in lane 0 -> out_parity[0]=1.

Source files
------------

// File: rtl/lane_gather_pkg.sv
// Shared types and helpers for the lane gather register.
//
// Contents
//   lg_state_e   : FILL (collecting narrow words) / HOLD (packed word presented)
//   lg_cnt_w     : width of a counter that must hold the values 0..n
//   lg_lane_idx  : maps a fill counter value to the physical lane it writes.
//                  The mapping is its own inverse, so it also maps a lane back
//                  to the counter value that writes it.
package lane_gather_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } lg_state_e;

    function automatic int lg_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // lsb_first=1: word k goes to lane k; otherwise word k goes to lane n-1-k.
    function automatic int lg_lane_idx(input int cnt, input int num_lanes, input bit lsb_first);
        return lsb_first ? cnt : (num_lanes - 1 - cnt);
    endfunction

endpackage

// File: rtl/lane_gather_reg.sv
// lane_gather_reg
//   Packs NUM_LANES narrow words, accepted one per cycle over a valid/ready
//   handshake, into one wide register. The packed word is presented both as a
//   flat bus and as per-lane slices of the same storage. A flush pulse closes
//   a partially filled word early; unfilled lanes then read 0.
//
// Parameters
//   LANE_W     bits per input word / output lane
//   NUM_LANES  words per packed output word (>= 2)
//   LSB_FIRST  1: first word lands in lane 0; 0: first word lands in lane NUM_LANES-1
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     narrow input handshake, in_data is the word
//   flush                 close the current partial word
//   out_valid/out_ready   packed output handshake
//   out_data              packed word, flat
//   out_lanes             packed word, one element per lane
//   out_count             number of filled lanes in the presented word
//   out_parity            (only with LANE_GATHER_PARITY_EN defined) even parity
//                         per lane, registered with the lane data; 0 for unfilled lanes
//
// Build option
//   LANE_GATHER_PARITY_EN  adds the out_parity port and its registers.
//
// Streaming: while a word is held, in_ready follows out_ready, so the first
// word of the next packet is captured in the same cycle the held word drains.
module lane_gather_reg
    import lane_gather_pkg::*;
#(
    parameter int LANE_W    = 8,
    parameter int NUM_LANES = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANE_W-1:0]             in_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*LANE_W-1:0]   out_data,
    output logic [LANE_W-1:0]             out_lanes [NUM_LANES],
    output logic [lg_cnt_w(NUM_LANES)-1:0] out_count
`ifdef LANE_GATHER_PARITY_EN
    ,
    output logic [NUM_LANES-1:0]          out_parity
`endif
);

    localparam int CNT_W = lg_cnt_w(NUM_LANES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LANES);

    localparam logic [0:0] ST_FILL = FILL;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [0:0]       state_reg;
    logic [0:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic             accept;
    logic [CNT_W-1:0] filled;
    logic             load_en;
    logic [CNT_W-1:0] load_cnt;
    logic             clear_all;

    assign in_ready = (state_reg == ST_FILL) || out_ready;
    assign accept   = in_valid && in_ready;

    // Lanes filled once this cycle's word (if any) is taken into account.
    assign filled   = cnt_reg + CNT_W'(accept);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        count_next = count_reg;
        load_en    = 1'b0;
        load_cnt   = cnt_reg;
        clear_all  = 1'b0;

        if (state_reg == ST_FILL) begin
            load_en  = accept;
            load_cnt = cnt_reg;
            if (accept && (cnt_reg == LAST_CNT)) begin
                state_next = ST_HOLD;
                count_next = FULL_CNT;
                cnt_next   = '0;
            end else if (flush && (filled != '0)) begin
                // Early close; lanes beyond 'filled' are still zero from the
                // last drain or reset.
                state_next = ST_HOLD;
                count_next = filled;
                cnt_next   = '0;
            end else begin
                cnt_next = filled;
            end
        end else begin
            // HOLD: flush has no effect; the word is already closed.
            if (out_ready) begin
                state_next = ST_FILL;
                count_next = '0;
                clear_all  = 1'b1;
                // A word accepted in the drain cycle opens the next packet.
                load_en    = accept;
                load_cnt   = '0;
                cnt_next   = CNT_W'(accept);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FILL;
            cnt_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            count_reg <= count_next;
        end
    end

    assign out_valid = (state_reg == ST_HOLD);
    assign out_count = count_reg;

    // One register per lane. Each lane knows at elaboration time which counter
    // value addresses it, so the write decode is a simple compare per lane.
    // A load takes priority over the drain-time clear so a word captured in
    // the drain cycle survives.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [CNT_W-1:0] SLOT =
                CNT_W'(lg_lane_idx(gi, NUM_LANES, LSB_FIRST != 0));

            logic [LANE_W-1:0] data_reg;
            logic              wr_en;

            assign wr_en = load_en && (load_cnt == SLOT);

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (wr_en) begin
                    data_reg <= in_data;
                end else if (clear_all) begin
                    data_reg <= '0;
                end
            end

            assign out_lanes[gi]                   = data_reg;
            assign out_data[gi*LANE_W +: LANE_W]   = data_reg;

`ifdef LANE_GATHER_PARITY_EN
            logic par_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    par_reg <= 1'b0;
                end else if (wr_en) begin
                    par_reg <= ^in_data;
                end else if (clear_all) begin
                    par_reg <= 1'b0;
                end
            end

            assign out_parity[gi] = par_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_lane_gather_reg.sv
// Bench for lane_gather_reg: two instances (LSB_FIRST=1 and LSB_FIRST=0) share
// one stimulus stream. A packet-level model (queue of accepted words, packed
// only when a packet closes) predicts the handshakes and packed outputs.
module tb_lane_gather_reg;

    localparam int LW = 8;
    localparam int NL = 4;
    localparam int CW = $clog2(NL + 1);
    localparam int DW = NL * LW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic [LW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          in_ready_a, out_valid_a;
    logic [DW-1:0] out_data_a;
    logic [LW-1:0] out_lanes_a [NL];
    logic [CW-1:0] out_count_a;
    logic          in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_b;
    logic [LW-1:0] out_lanes_b [NL];
    logic [CW-1:0] out_count_b;
`ifdef LANE_GATHER_PARITY_EN
    logic [NL-1:0] out_parity_a, out_parity_b;
`endif

    lane_gather_reg #(.LANE_W(LW), .NUM_LANES(NL), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_lanes(out_lanes_a),
        .out_count(out_count_a)
`ifdef LANE_GATHER_PARITY_EN
        , .out_parity(out_parity_a)
`endif
    );

    lane_gather_reg #(.LANE_W(LW), .NUM_LANES(NL), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_lanes(out_lanes_b),
        .out_count(out_count_b)
`ifdef LANE_GATHER_PARITY_EN
        , .out_parity(out_parity_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            holding = 1'b0;
    logic [LW-1:0] q[$];
    logic [DW-1:0] held_a, held_b;
    int            held_cnt;

    // Observations from the DUT
    int handshakes = 0;
    int ready_low  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_q(input bit lsb);
        logic [DW-1:0] r;
        int lane;
        r = '0;
        for (int i = 0; i < q.size(); i++) begin
            lane = lsb ? i : (NL - 1 - i);
            r[lane*LW +: LW] = q[i];
        end
        return r;
    endfunction

    function automatic logic [NL-1:0] parity_of(input logic [DW-1:0] w);
        logic [NL-1:0] p;
        for (int k = 0; k < NL; k++) p[k] = ^w[k*LW +: LW];
        return p;
    endfunction

    task automatic step(input bit r, input bit v, input logic [LW-1:0] d,
                        input bit f, input bit ordy);
        bit            exp_rdy, acc;
        logic [DW-1:0] exp_a, exp_b, lanes_a, lanes_b;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = v ? d : LW'($urandom);  // garbage on idle cycles must be ignored
        flush     = f;
        out_ready = ordy;
        #1;
        exp_rdy = !holding || ordy;
        check("in_ready_lsb", 64'(in_ready_a), 64'(exp_rdy));
        check("in_ready_msb", 64'(in_ready_b), 64'(exp_rdy));
        if (out_valid_a && ordy) handshakes++;
        if (!in_ready_a) ready_low++;
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            holding = 1'b0;
            q.delete();
        end else if (!holding) begin
            if (acc) q.push_back(d);
            if (q.size() == NL || (f && q.size() > 0)) begin
                holding  = 1'b1;
                held_a   = pack_q(1'b1);
                held_b   = pack_q(1'b0);
                held_cnt = q.size();
                q.delete();
            end
        end else if (ordy) begin
            holding = 1'b0;
            q.delete();
            if (acc) q.push_back(d);
        end
        #1;
        exp_a = holding ? held_a : pack_q(1'b1);
        exp_b = holding ? held_b : pack_q(1'b0);
        for (int k = 0; k < NL; k++) begin
            lanes_a[k*LW +: LW] = out_lanes_a[k];
            lanes_b[k*LW +: LW] = out_lanes_b[k];
        end
        check("out_valid_lsb", 64'(out_valid_a), 64'(holding));
        check("out_valid_msb", 64'(out_valid_b), 64'(holding));
        check("out_data_lsb", 64'(out_data_a), 64'(exp_a));
        check("out_data_msb", 64'(out_data_b), 64'(exp_b));
        check("out_lanes_lsb", 64'(lanes_a), 64'(exp_a));
        check("out_lanes_msb", 64'(lanes_b), 64'(exp_b));
        if (holding) begin
            check("out_count_lsb", 64'(out_count_a), 64'(held_cnt));
            check("out_count_msb", 64'(out_count_b), 64'(held_cnt));
        end
`ifdef LANE_GATHER_PARITY_EN
        if (holding) begin
            check("out_parity_lsb", 64'(out_parity_a), 64'(parity_of(exp_a)));
            check("out_parity_msb", 64'(out_parity_b), 64'(parity_of(exp_b)));
        end
`endif
        $display("step rst=%0b v=%0b d=%02h flush=%0b ordy=%0b -> valid=%0b data=%08h/%08h cnt=%0d",
                 r, v, d, f, ordy, out_valid_a, out_data_a, out_data_b, out_count_a);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h99, 1, 1);
        check("count_after_reset", 64'(out_count_a), 64'd0);
        check("data_after_reset", 64'(out_data_a), 64'd0);

        // Four words back to back; packet visible one cycle after the last word
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h33, 0, 0);
        check("not_valid_before_last", 64'(out_valid_a), 64'd0);
        step(0, 1, 8'h44, 0, 0);
        check("pack_lsb_first", 64'(out_data_a), 64'h44332211);
        check("pack_msb_first", 64'(out_data_b), 64'h11223344);
        check("full_count", 64'(out_count_a), 64'd4);

        // Backpressure: held word stable, input stalled, flush ignored
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), (i == 2), 0);
        check("held_stable", 64'(out_data_a), 64'h44332211);

        // Drain with a simultaneous word: it lands in the first lane
        step(0, 1, 8'h55, 0, 1);
        check("drain_capture_lsb", 64'(out_data_a), 64'h00000055);
        check("drain_capture_msb", 64'(out_data_b), 64'h55000000);

        // Close {55} by flush, drain it, then a two-word flush
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'hA1, 0, 0);
        step(0, 1, 8'hB2, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("flush_pack", 64'(out_data_a), 64'h0000B2A1);
        check("flush_count", 64'(out_count_a), 64'd2);
        step(0, 0, 8'h00, 0, 1);
        // Flush with nothing collected is ignored
        step(0, 0, 8'h00, 1, 1);
        check("empty_flush", 64'(out_valid_a), 64'd0);
        // Flush in the same cycle as the first word closes a one-lane packet
        step(0, 1, 8'hC3, 1, 0);
        check("flush_with_word_count", 64'(out_count_a), 64'd1);
        step(0, 0, 8'h00, 0, 1);

        // Sustained streaming: 16 words, consumer always ready
        handshakes = 0;
        ready_low  = 0;
        for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), 0, 1);
        step(0, 0, 8'h00, 0, 1);
        check("stream_packets", 64'(handshakes), 64'd4);
        check("stream_no_stall", 64'(ready_low), 64'd0);

        // Reset mid-packet, then a clean packet
        step(0, 1, 8'hDE, 0, 0);
        step(0, 1, 8'hAD, 0, 0);
        step(0, 1, 8'hBE, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        check("rst_mid_valid", 64'(out_valid_a), 64'd0);
        check("rst_mid_data", 64'(out_data_a), 64'd0);
        step(0, 1, 8'h07, 0, 0);
        step(0, 1, 8'h01, 0, 0);
        step(0, 1, 8'h02, 0, 0);
        step(0, 1, 8'h03, 0, 0);
        check("post_rst_pack", 64'(out_data_a), 64'h03020107);
`ifdef LANE_GATHER_PARITY_EN
        check("parity_lane0", 64'(out_parity_a[0]), 64'd1);
`endif
        step(0, 0, 8'h00, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
